// File: rtl/input_conditioner_if.sv
// Signal bundle between the direction switch and the input conditioner.
// The master side drives the raw switch; the slave side (the conditioner) returns clean controls.
interface input_conditioner_if;
  logic sw_0;
  logic dir;
  logic dir_changed;
  logic count_en;

  modport master (output sw_0, input dir, input dir_changed, input count_en);
  modport slave  (input sw_0, output dir, output dir_changed, output count_en);
endinterface

// File: rtl/input_conditioner.sv
// Synchronises and debounces the direction switch, flags direction changes and
// produces the divided count_en tick whose phase restarts on every reversal.
module input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TICK_DIV        = 4
) (
  input logic              gclk10,
  input logic              btn_center,
  input_conditioner_if.slave io
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [DIV_W-1:0]       div_q;
  logic                   dir_q;
  logic                   dir_changed_q;
  logic                   count_en_q;
  logic                   s;
  logic                   accept;

  assign s      = sync_q[SYNC_STAGES-1];
  assign accept = (s != dir_q) && (cnt_q == CNT_MAX);

  always_ff @(posedge gclk10) begin
    if (btn_center) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], io.sw_0};
    end
  end

  // Any return of s to the accepted level throws away the partial count.
  always_ff @(posedge gclk10) begin
    if (btn_center) begin
      cnt_q         <= '0;
      dir_q         <= 1'b0;
      dir_changed_q <= 1'b0;
    end else begin
      dir_changed_q <= accept;
      if (s == dir_q) begin
        cnt_q <= '0;
      end else if (accept) begin
        dir_q <= s;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // A direction change restarts the tick phase so the counter never steps as dir flips.
  always_ff @(posedge gclk10) begin
    if (btn_center) begin
      div_q      <= '0;
      count_en_q <= 1'b0;
    end else if (accept) begin
      div_q      <= '0;
      count_en_q <= 1'b0;
    end else if (div_q == DIV_MAX) begin
      div_q      <= '0;
      count_en_q <= 1'b1;
    end else begin
      div_q      <= div_q + 1'b1;
      count_en_q <= 1'b0;
    end
  end

  assign io.dir         = dir_q;
  assign io.dir_changed = dir_changed_q;
  assign io.count_en    = count_en_q;

endmodule
